// File: rtl/branch_pc_ctrl_pkg.sv
// Shared rv32 fetch-control definitions: PC-select encodings and BTB counter constants.
package branch_pc_ctrl_pkg;

  typedef enum logic [1:0] {
    IF_PC_PLUS_4  = 2'd0,
    IF_P_T_PC     = 2'd1,
    EXE_PC_PLUS_4 = 2'd2,
    EXE_T_PC      = 2'd3
  } pc_sel_e;

  localparam logic [1:0] CTR_RST       = 2'd1;  // weakly not-taken
  localparam logic [1:0] CTR_ALLOC_JMP = 2'd3;
  localparam logic [1:0] CTR_ALLOC_BR  = 2'd2;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'd3) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'd0) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/branch_pc_ctrl_btb_table.sv
// Direct-mapped BTB storage: two combinational read ports (IF lookup, EXE lookup)
// and one synchronous write port; async reset invalidates every entry.
module btb_table
  import branch_pc_ctrl_pkg::*;
#(
  parameter int AW      = 16,
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = AW - IDX_W - 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [AW-1:0]    rd_target,
  output logic [1:0]       rd_ctr,
  input  logic [IDX_W-1:0] ex_idx,
  output logic             ex_valid,
  output logic [TAG_W-1:0] ex_tag,
  output logic [AW-1:0]    ex_target,
  output logic [1:0]       ex_ctr,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [AW-1:0]    wr_target,
  input  logic [1:0]       wr_ctr
);

  logic [ENTRIES-1:0]            valid_q, valid_d;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [ENTRIES-1:0][AW-1:0]    target_q, target_d;
  logic [ENTRIES-1:0][1:0]       ctr_q, ctr_d;

  // Read ports see registered contents, so a same-cycle write shows up next cycle
  assign rd_valid  = valid_q[rd_idx];
  assign rd_tag    = tag_q[rd_idx];
  assign rd_target = target_q[rd_idx];
  assign rd_ctr    = ctr_q[rd_idx];
  assign ex_valid  = valid_q[ex_idx];
  assign ex_tag    = tag_q[ex_idx];
  assign ex_target = target_q[ex_idx];
  assign ex_ctr    = ctr_q[ex_idx];

  // Next-state: a write always leaves the entry valid
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (we) begin
      valid_d[wr_idx]  = 1'b1;
      tag_d[wr_idx]    = wr_tag;
      target_d[wr_idx] = wr_target;
      ctr_d[wr_idx]    = wr_ctr;
    end
  end

  // Storage registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      tag_q    <= '0;
      target_q <= '0;
      ctr_q    <= {ENTRIES{CTR_RST}};
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_pc_ctrl.sv
// Fetch-stage branch predictor and PC-select controller: BTB lookup in IF,
// resolution/update in EXE, flush on mispredict, perf counters.
module branch_pc_ctrl
  import branch_pc_ctrl_pkg::*;
#(
  parameter int addrWidth   = 16,
  parameter int BTB_ENTRIES = 16,
  parameter int IDX_W       = $clog2(BTB_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Hcf,
  input  logic                 Stall,
  input  logic [addrWidth-1:0] IF_pc,
  input  logic                 EXE_br_valid,
  input  logic                 EXE_is_jump,
  input  logic                 EXE_taken,
  input  logic [addrWidth-1:0] EXE_pc,
  input  logic [addrWidth-1:0] EXE_Target_pc,
  input  logic                 EXE_pred_taken,
  input  logic [addrWidth-1:0] EXE_pred_target,
  output logic [1:0]           PCSel,
  output logic [addrWidth-1:0] Predict_Target_pc,
  output logic                 IF_pred_taken,
  output logic                 Flush,
  output logic [31:0]          br_cnt,
  output logic [31:0]          mis_cnt
);

  localparam int TAG_W = addrWidth - IDX_W - 2;

  logic             rd_valid, ex_valid, we;
  logic [TAG_W-1:0] rd_tag, ex_tag;
  logic [addrWidth-1:0] rd_target, ex_target, wr_target;
  logic [1:0]       rd_ctr, ex_ctr, wr_ctr;
  logic             if_hit, ex_hit, resolve, eff_taken, mispredict;
  logic [31:0]      br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;
  pc_sel_e          pc_sel;
  logic             unused_bits;

  wire [TAG_W-1:0] if_tag_w = IF_pc[addrWidth-1:IDX_W+2];
  wire [TAG_W-1:0] ex_tag_w = EXE_pc[addrWidth-1:IDX_W+2];

  btb_table #(.AW(addrWidth), .ENTRIES(BTB_ENTRIES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_btb (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (IF_pc[IDX_W+1:2]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_target(rd_target),
    .rd_ctr   (rd_ctr),
    .ex_idx   (EXE_pc[IDX_W+1:2]),
    .ex_valid (ex_valid),
    .ex_tag   (ex_tag),
    .ex_target(ex_target),
    .ex_ctr   (ex_ctr),
    .we       (we),
    .wr_idx   (EXE_pc[IDX_W+1:2]),
    .wr_tag   (ex_tag_w),
    .wr_target(wr_target),
    .wr_ctr   (wr_ctr)
  );

  assign unused_bits = ^{IF_pc[1:0], EXE_pc[1:0], rd_ctr[0]};

  assign if_hit            = rd_valid && (rd_tag == if_tag_w);
  assign IF_pred_taken     = if_hit && rd_ctr[1];
  assign Predict_Target_pc = IF_pred_taken ? rd_target : '0;

  assign ex_hit     = ex_valid && (ex_tag == ex_tag_w);
  assign resolve    = EXE_br_valid && !Stall && !Hcf;
  assign eff_taken  = EXE_taken || EXE_is_jump;
  assign mispredict = resolve && ((eff_taken != EXE_pred_taken) ||
                                  (eff_taken && (EXE_pred_target != EXE_Target_pc)));
  assign Flush      = mispredict;
  assign PCSel      = pc_sel;

  // Next-PC select, EXE redirect outranks IF prediction
  always_comb begin
    pc_sel = IF_PC_PLUS_4;
    if (mispredict && eff_taken)       pc_sel = EXE_T_PC;
    else if (mispredict)               pc_sel = EXE_PC_PLUS_4;
    else if (IF_pred_taken && !Hcf)    pc_sel = IF_P_T_PC;
  end

  // BTB write: train/allocate on taken, weaken on not-taken hit
  always_comb begin
    we        = 1'b0;
    wr_target = ex_target;
    wr_ctr    = ex_ctr;
    if (resolve) begin
      if (eff_taken) begin
        we        = 1'b1;
        wr_target = EXE_Target_pc;
        wr_ctr    = ex_hit ? ctr_inc(ex_ctr) : (EXE_is_jump ? CTR_ALLOC_JMP : CTR_ALLOC_BR);
      end else if (ex_hit) begin
        we     = 1'b1;
        wr_ctr = ctr_dec(ex_ctr);
      end
    end
  end

  // Perf counter next-state, free-running wrap
  always_comb begin
    br_cnt_d  = br_cnt_q + {31'd0, resolve};
    mis_cnt_d = mis_cnt_q + {31'd0, mispredict};
  end

  // Perf counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign br_cnt  = br_cnt_q;
  assign mis_cnt = mis_cnt_q;

endmodule
